// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store sequencer between execute and the
//            memory data port; sizes, extends and fault-checks each access.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_fetch_addr,
    input  logic [31:0] mem_fetched_data,
    output logic [2:0]  mem_bytes_to_write,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic        r_resp_fault;

    logic        w_req_fault;
    logic [31:0] w_load_ext;
    logic [2:0]  w_bytes;

    // Fault is decided once, from the incoming request, so ACCESS only
    // ever looks at registered state.
    always_comb begin
        w_req_fault = 1'b0;
        if (req_size == 2'd3) begin
            w_req_fault = 1'b1;
        end else if (ALLOW_MISALIGNED == 1'b0) begin
            if ((req_size == 2'd1) && req_addr[0])
                w_req_fault = 1'b1;
            if ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                w_req_fault = 1'b1;
        end
    end

    always_comb begin
        w_load_ext = mem_fetched_data;
        case (r_size)
            2'd0:    w_load_ext = {{24{~r_unsigned & mem_fetched_data[7]}},
                                   mem_fetched_data[7:0]};
            2'd1:    w_load_ext = {{16{~r_unsigned & mem_fetched_data[15]}},
                                   mem_fetched_data[15:0]};
            default: w_load_ext = mem_fetched_data;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP:   if (resp_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_store      <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_fault      <= 1'b0;
            r_rdata      <= 32'd0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && req_valid) begin
                r_store    <= req_store;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_fault    <= w_req_fault;
            end
            if (r_state == ST_ACCESS) begin
                r_resp_fault <= r_fault;
                r_rdata      <= (r_fault || r_store) ? 32'd0 : w_load_ext;
            end
        end
    end

    // Strobe depends only on registered state; async reset kills it at once.
    always_comb begin
        w_bytes = 3'd0;
        if ((r_state == ST_ACCESS) && r_store && !r_fault) begin
            case (r_size)
                2'd0:    w_bytes = 3'd1;
                2'd1:    w_bytes = 3'd2;
                default: w_bytes = 3'd4;
            endcase
        end
    end

    assign req_ready          = (r_state == ST_IDLE);
    assign resp_valid         = (r_state == ST_RESP);
    assign resp_rdata         = r_rdata;
    assign resp_fault         = r_resp_fault;
    assign mem_fetch_addr     = r_addr;
    assign mem_write_addr     = r_addr;
    assign mem_write_data     = r_wdata;
    assign mem_bytes_to_write = w_bytes;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the data port of `memory`.
- Accepts one load or store request at a time over a valid/ready handshake and drives `memory`'s `fetch_addr`, `bytes_to_write`, `write_addr` and `write_data`.
- For loads, captures `fetched_data`, then size-extends it and sign- or zero-extends it to 32 bits.
- Returns a registered response over a second valid/ready handshake, with a fault flag for illegal sizes or disallowed misalignment.

Parameters:
- ALLOW_MISALIGNED, 1: 1 passes unaligned half/word accesses through to memory (memory is byte-addressed, little-endian); 0 faults them.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_store  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  input  1  loads only: 1 zero-extend, 0 sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low bytes used
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_fault  output  1  request was not performed
- mem_fetch_addr  output  32  to memory `fetch_addr`
- mem_fetched_data  input  32  from memory `fetched_data` (combinational read)
- mem_bytes_to_write  output  3  to memory `bytes_to_write`; 0 = no write
- mem_write_addr  output  32  to memory `write_addr`
- mem_write_data  output  32  to memory `write_data`

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst=0, takes effect immediately):
  - state=IDLE; request and response registers cleared.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_bytes_to_write=0.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: latch store, size, unsigned, addr, wdata; go to ACCESS.
- Fault decode at latch:
  - size=3 faults.
  - With ALLOW_MISALIGNED=0: half with addr[0]≠0 faults; word with addr[1:0]≠0 faults.
- ACCESS (exactly one cycle), req_ready=0:
  - Store without fault: mem_write_addr=addr; mem_write_data=wdata; mem_bytes_to_write = 1, 2 or 4 for size 0, 1 or 2. The memory commits at the edge ending ACCESS.
  - Load without fault: mem_fetch_addr=addr. At the edge ending ACCESS, register the extended data:
    - byte: bits[7:0], extended from bit 7
    - half: bits[15:0], extended from bit 15
    - word: unchanged
  - Fault: no memory write; rdata register=0; fault register=1.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_fault held stable until an edge with resp_ready=1, then go to IDLE.
  - req_ready=0 throughout.
- mem_bytes_to_write is 0 in every state except ACCESS with a non-faulting store. It is decoded from registered state only, with no combinational path from req_* or resp_ready.
- mem_fetch_addr, mem_write_addr and mem_write_data are driven from the latched request in all states; their values do not matter when no access is active.
- Latency and throughput:
  - Request accepted at edge N; resp_valid=1 after edge N+1.
  - With resp_ready held at 1, next req_ready=1 after edge N+2: one access per 3 cycles.
- Ordering: a load accepted after a store's response sees the stored data.
- Reset mid-ACCESS: the write strobe drops to 0 asynchronously and no write occurs. Reset mid-RESP discards the response.
- Requests presented while req_ready=0 are ignored; the requester holds them until accepted.

Test Plan:
- Word store/load: store addr 0x100, data 0xdeadbeef, size 2 → mem_bytes_to_write=4 for one cycle. Load 0x100 word → resp_rdata=0xdeadbeef, fault=0, resp_valid one cycle after ACCESS.
- Sub-word extension: memory word 0x100 = 0xdead80fe.
  - signed byte @0x100 → 0xfffffffe
  - unsigned byte → 0x000000fe
  - signed half @0x100 → 0xffff80fe
  - unsigned half @0x102 → 0x0000dead
- Partial store: store half 0xb0bacafe @0x104 over 0xdeadbeef → subsequent word load reads 0xdeadcafe. Store byte 0x00 @0x101 over 0xaabbccdd → word load @0x100 reads 0xaabb00dd.
- Faults:
  - size=3 load → resp_fault=1, rdata=0, mem_bytes_to_write stays 0.
  - With ALLOW_MISALIGNED=0, word store @0x101 → fault, memory unchanged.
  - With ALLOW_MISALIGNED=1, word load @0x101 over bytes 0x100..0x104 = 00 dd cc bb aa → 0xaabbccdd.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored. Release → IDLE next cycle.
- Reset mid-operation: assert rst=0 during ACCESS of store 0x12345678 @0x108 → mem_bytes_to_write drops to 0 immediately. After release, word @0x108 still holds its old value and resp_valid=0.
